// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: capture FSM encoding
// and default buffer geometry.
package uart_rx_fifo_pkg;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_THRESH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Receive buffer storage: one synchronous write port, one asynchronous
// read port, contents deliberately left without reset.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each byte offered on rec_valid exactly once,
// acknowledges it with rr, and queues it for the bus side (first-word-fall-through).
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int THRESH = DEFAULT_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rec_data,
  input  logic                   rec_valid,
  output logic                   rr,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic                   irq,
  output cap_state_e             cap_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_LVL = LW'(THRESH);

  // Handshake: a byte is taken on the edge where the FSM is IDLE and
  // rec_valid is high; rr pulses the following cycle, and a new byte is
  // only accepted after rec_valid has been seen low again.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    head;
  logic          capture;
  logic          pop;
  logic          wr_ok;

  assign capture = (cap_state == IDLE) && rec_valid;
  assign pop     = rd_en && !empty;
  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign wr_ok   = capture && (!full || pop);

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign rd_data = empty ? 8'h00 : head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_state <= IDLE;
      rr        <= 1'b0;
    end else begin
      rr <= 1'b0;
      case (cap_state)
        IDLE: begin
          if (rec_valid) begin
            cap_state <= ACK;
            rr        <= 1'b1;
          end
        end
        ACK:      cap_state <= WAIT_LOW;
        WAIT_LOW: if (!rec_valid) cap_state <= IDLE;
        default:  cap_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_ok) - LW'(pop);
      // A dropped byte outranks a simultaneous clear.
      if (capture && !wr_ok) overrun <= 1'b1;
      else if (clr_ovr)      overrun <= 1'b0;
      irq <= (level >= THRESH_LVL) || overrun;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (rec_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture handshake, fill/drain ordering,
// overrun, simultaneous push/pop, level-held rec_valid and async reset.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rec_data;
  logic       rec_valid;
  logic       rr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       clr_ovr;
  logic       irq;
  cap_state_e cap_state;

  int n_cmp = 0;
  int n_err = 0;
  int rr_cnt = 0;
  int rr_base;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .THRESH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rec_data  (rec_data),
    .rec_valid (rec_valid),
    .rr        (rr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .irq       (irq),
    .cap_state (cap_state)
  );

  always @(negedge clk) if (rr === 1'b1) rr_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [7:0] b, input logic pop_i, input logic clr_i);
    rec_data  = b;
    rec_valid = 1'b1;
    rd_en     = pop_i;
    clr_ovr   = clr_i;
    tick();
    rd_en   = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic finish_byte();
    tick();
    rec_valid = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    capture(b, 1'b0, 1'b0);
    finish_byte();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rec_data = 8'h00; rec_valid = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    tick();
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_rr", rr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_state", cap_state, IDLE);
    reset = 1'b1;
    tick();

    // Single byte
    rr_base = rr_cnt;
    capture(8'h48, 1'b0, 1'b0);
    chk("single_level", level, 1);
    chk("single_empty", empty, 0);
    chk("single_rd_data", rd_data, 8'h48);
    chk("single_rr_hi", rr, 1);
    chk("single_state_ack", cap_state, ACK);
    finish_byte();
    chk("single_rr_count", rr_cnt - rr_base, 1);
    chk("single_irq", irq, 0);
    chk("single_state_idle", cap_state, IDLE);
    pop_one();
    chk("single_pop_empty", empty, 1);
    chk("single_pop_rd_data", rd_data, 8'h00);

    // Fill to 16, irq from level 8
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      exp_q.push_back(8'(i));
      chk("fill_level", level, i + 1);
      chk("fill_irq", irq, (i >= 7) ? 1 : 0);
    end
    chk("fill_full", full, 1);
    chk("fill_head", rd_data, 8'h00);

    // Overrun, then clear
    rr_base = rr_cnt;
    send_byte(8'hAA);
    chk("ovr_rr_count", rr_cnt - rr_base, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_irq", irq, 1);
    chk("ovr_level", level, 16);
    chk("ovr_head", rd_data, 8'h00);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Overrun coincident with clear: overrun stays set
    capture(8'hBB, 1'b0, 1'b1);
    chk("ovr_vs_clr", overrun, 1);
    finish_byte();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr2", overrun, 0);

    // Simultaneous capture and pop while full
    capture(8'h55, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    chk("sim_level", level, 16);
    chk("sim_overrun", overrun, 0);
    chk("sim_head", rd_data, 8'h01);
    finish_byte();

    // Drain in order; 8'h55 is the tail
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rd_data, exp_q.pop_front());
      pop_one();
    end
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_rd_data", rd_data, 8'h00);
    tick();
    chk("drain_irq", irq, 0);

    // Pop while empty is ignored
    pop_one();
    chk("emptypop_level", level, 0);
    send_byte(8'h77);
    chk("emptypop_data", rd_data, 8'h77);
    chk("emptypop_level1", level, 1);
    pop_one();

    // rec_valid held high for 10 cycles
    rr_base = rr_cnt;
    rec_data  = 8'h3C;
    rec_valid = 1'b1;
    repeat (10) tick();
    chk("hold_rr_count", rr_cnt - rr_base, 1);
    chk("hold_level", level, 1);
    chk("hold_state", cap_state, WAIT_LOW);
    rec_valid = 1'b0;
    tick();
    chk("hold_data", rd_data, 8'h3C);
    pop_one();

    // Async reset during ACK with level 3, then capture on first edge
    send_byte(8'h11);
    send_byte(8'h22);
    capture(8'h33, 1'b0, 1'b0);
    chk("mrst_pre_level", level, 3);
    chk("mrst_pre_state", cap_state, ACK);
    chk("mrst_pre_rr", rr, 1);
    #2 reset = 1'b0;
    #1;
    chk("mrst_rr", rr, 0);
    chk("mrst_level", level, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_state", cap_state, IDLE);
    chk("mrst_rd_data", rd_data, 8'h00);
    reset = 1'b1;
    tick();
    chk("mrst_recap_level", level, 1);
    chk("mrst_recap_data", rd_data, 8'h33);
    chk("mrst_recap_rr", rr, 1);
    finish_byte();
    pop_one();
    chk("final_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, receive buffer entries; power of two, minimum 2.
REQ-002 SHALL have parameter THRESH, default 8, level at or above which irq asserts; range 1..DEPTH.
REQ-003 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rec_data, input, 8, received byte from the uart receiver.
REQ-006 SHALL have port rec_valid, input, 1, level from the uart receiver, high while rec_data holds an unacknowledged byte.
REQ-007 SHALL have port rr, output, 1, receive-read acknowledge to the uart receiver, one-cycle pulse.
REQ-008 SHALL have port rd_en, input, 1, pop request from the bus side.
REQ-009 SHALL have port rd_data, output, 8, head entry, first-word-fall-through.
REQ-010 SHALL have port empty, output, 1, buffer holds no entries.
REQ-011 SHALL have port full, output, 1, buffer holds DEPTH entries.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1, current entry count 0..DEPTH.
REQ-013 SHALL have port overrun, output, 1, sticky flag: a byte was dropped.
REQ-014 SHALL have port clr_ovr, input, 1, clears overrun.
REQ-015 SHALL have port irq, output, 1, registered (level >= THRESH) OR overrun.

Function
REQ-016 SHALL implement capture FSM states IDLE, ACK, WAIT_LOW.
REQ-017 In IDLE with rec_valid sampled high, SHALL capture rec_data on that edge, go to ACK, and drive rr high for the next cycle only.
REQ-018 ACK SHALL last exactly one cycle, then go to WAIT_LOW unconditionally.
REQ-019 WAIT_LOW SHALL return to IDLE on the first edge with rec_valid sampled low; no capture in ACK or WAIT_LOW.
REQ-020 SHALL write a captured byte at the capture edge; empty deasserts and level increments on that edge.
REQ-021 Capture while full without a simultaneous pop SHALL drop the byte, set overrun, still pulse rr, and leave pointers and level unchanged.
REQ-022 Capture and pop on the same edge SHALL both succeed, including when full; level is unchanged and no overrun occurs.
REQ-023 rd_en while empty SHALL be ignored; no pointer or level change.
REQ-024 rd_data SHALL equal the head entry when not empty and 8'h00 when empty.
REQ-025 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; full/empty SHALL derive from level.
REQ-026 clr_ovr SHALL clear overrun on the next edge; a simultaneous overrun event SHALL win and leave overrun set.
REQ-027 irq SHALL update one edge after the level or overrun change that causes it.

Reset
REQ-028 Asserting reset low SHALL asynchronously force FSM=IDLE, rr=0, pointers=0, level=0, empty=1, full=0, overrun=0, irq=0.
REQ-029 Storage contents SHALL NOT require reset.
REQ-030 After reset release with rec_valid already high, the first rising edge SHALL capture that byte.

Structure
REQ-031 SHALL place the FSM state encoding and the default DEPTH/THRESH constants in a shared uart package.
REQ-032 SHALL isolate storage in one sub-module, uart_fifo_mem: one write port and one asynchronous read port, no reset.

Verification
REQ-033 Single byte: serial 8'h48 via uart, rec_valid high -> one rr pulse, level=1, rd_data=8'h48, irq=0.
REQ-034 Fill: 16 bytes 8'h00..8'h0F -> full=1, irq high from level 8; popping 16 returns 00..0F in order, then empty=1.
REQ-035 Overrun: 17th byte 8'hAA with full=1 -> rr pulses, overrun=1, irq=1, level stays 16; clr_ovr -> overrun=0 next edge.
REQ-036 Simultaneous: full, capture 8'h55 and pop on the same edge -> level 16, no overrun, tail entry is 8'h55.
REQ-037 Level hold: rec_valid held high 10 cycles -> exactly one capture and one rr pulse.
REQ-038 Mid-operation reset: assert reset during ACK with level=3 -> rr=0, level=0, empty=1 immediately, without waiting for a clock edge.
